// File: rtl/stepper_position_ctrl.sv
// Stepper position controller: walks current_pos toward target_pos one step pulse at a time,
// with direction setup time before any reversal. Define MOTOR_WRAP_EN for modulo-revolution positioning.
module stepper_position_ctrl #(
    parameter int STEP_PERIOD   = 50000,
    parameter int PULSE_WIDTH   = 5000,
    parameter int DIR_SETUP     = 100,
    parameter int STEPS_PER_REV = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] target_pos,
    output logic        step,
    output logic        dir,
    output logic [31:0] current_pos,
    output logic        busy,
    output logic        at_target
);
    typedef enum logic [1:0] {IDLE, SETUP, PULSE_HI, PULSE_LO} state_t;

    localparam logic [31:0] SETUP_LOAD = 32'(DIR_SETUP - 1);
    localparam logic [31:0] HI_LOAD    = 32'(PULSE_WIDTH - 1);
    localparam logic [31:0] LO_LOAD    = 32'(STEP_PERIOD - PULSE_WIDTH - 1);

    state_t      state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [31:0] pos_nxt;
    logic        dir_nxt;
    logic [31:0] eff_target;
    logic        want_up;
    logic        need_move;
    logic [31:0] pos_inc, pos_dec;

`ifdef MOTOR_WRAP_EN
    localparam logic [31:0] SPR = 32'(STEPS_PER_REV);
    logic [31:0] fwd_dist;

    // Position lives on a ring of SPR steps; take the shorter way round, ties forward.
    always_comb begin
        eff_target = target_pos % SPR;
        fwd_dist   = (eff_target >= current_pos) ? (eff_target - current_pos)
                                                 : (eff_target + SPR - current_pos);
        want_up    = (fwd_dist <= (SPR >> 1));
        pos_inc    = (current_pos == SPR - 32'd1) ? 32'd0 : current_pos + 32'd1;
        pos_dec    = (current_pos == 32'd0) ? SPR - 32'd1 : current_pos - 32'd1;
    end
`else
    logic [31:0] unused_spr;
    assign unused_spr = 32'(STEPS_PER_REV);

    always_comb begin
        eff_target = target_pos;
        want_up    = ($signed(target_pos) > $signed(current_pos));
        pos_inc    = current_pos + 32'd1;
        pos_dec    = current_pos - 32'd1;
    end
`endif

    assign need_move = (eff_target != current_pos);
    assign at_target = (state == IDLE) && !need_move;

    // Target and enable are only looked at in IDLE and at the end of each step period.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
        dir_nxt   = dir;
        pos_nxt   = current_pos;
        case (state)
            IDLE: begin
                if (en && need_move) begin
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LOAD;
                    dir_nxt   = want_up;
                end
            end
            SETUP: begin
                if (cnt == 32'd0) begin
                    state_nxt = PULSE_HI;
                    cnt_nxt   = HI_LOAD;
                end
            end
            PULSE_HI: begin
                if (cnt == 32'd0) begin
                    state_nxt = PULSE_LO;
                    cnt_nxt   = LO_LOAD;
                    pos_nxt   = dir ? pos_inc : pos_dec;
                end
            end
            PULSE_LO: begin
                if (cnt == 32'd0) begin
                    if (!en || !need_move) begin
                        state_nxt = IDLE;
                    end else if (want_up == dir) begin
                        state_nxt = PULSE_HI;
                        cnt_nxt   = HI_LOAD;
                    end else begin
                        state_nxt = SETUP;
                        cnt_nxt   = SETUP_LOAD;
                        dir_nxt   = want_up;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // step and busy are registered from the next state so the driver sees clean edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 32'd0;
            dir         <= 1'b0;
            current_pos <= 32'd0;
            step        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            dir         <= dir_nxt;
            current_pos <= pos_nxt;
            step        <= (state_nxt == PULSE_HI);
            busy        <= (state_nxt != IDLE);
        end
    end
endmodule

// File: tb/tb_stepper_position_ctrl.sv
// Scoreboard bench for stepper_position_ctrl: a path-level model queues expected step and
// move-complete events; a monitor pops them as the DUT produces pulses and finishes moves.
`timescale 1ns/1ps
module tb_stepper_position_ctrl;
    localparam int STEP_PERIOD = 10;
    localparam int PULSE_WIDTH = 3;
    localparam int DIR_SETUP   = 2;
    localparam int SPR         = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] target_pos;
    logic        step;
    logic        dir;
    logic [31:0] current_pos;
    logic        busy;
    logic        at_target;

    stepper_position_ctrl #(
        .STEP_PERIOD(STEP_PERIOD),
        .PULSE_WIDTH(PULSE_WIDTH),
        .DIR_SETUP(DIR_SETUP),
        .STEPS_PER_REV(SPR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .target_pos(target_pos),
        .step(step),
        .dir(dir),
        .current_pos(current_pos),
        .busy(busy),
        .at_target(at_target)
    );

    always #5 clk = ~clk;

    // done=0: a step pulse ending with pos/dir; done=1: move finished with pos/at_target.
    typedef struct {
        bit          done;
        logic [31:0] pos;
        logic        flag;
    } ev_t;

    ev_t         sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_pos;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] eff_of(input logic [31:0] t);
`ifdef MOTOR_WRAP_EN
        return t % SPR;
`else
        return t;
`endif
    endfunction

    function automatic bit goes_up(input logic [31:0] cur, input logic [31:0] tgt);
`ifdef MOTOR_WRAP_EN
        return ((tgt + SPR - cur) % SPR) <= (SPR / 2);
`else
        return $signed(tgt) > $signed(cur);
`endif
    endfunction

    function automatic logic [31:0] advance(input logic [31:0] cur, input bit up);
`ifdef MOTOR_WRAP_EN
        return up ? (cur + 1) % SPR : (cur + SPR - 1) % SPR;
`else
        return up ? cur + 32'd1 : cur - 32'd1;
`endif
    endfunction

    task automatic pushStep();
        bit up;
        up        = goes_up(model_pos, eff_of(target_pos));
        model_pos = advance(model_pos, up);
        sb.push_back('{done: 1'b0, pos: model_pos, flag: up});
    endtask

    task automatic planMove(input logic [31:0] tgt);
        logic [31:0] t;
        bit          up;
        bit          moved;
        t     = eff_of(tgt);
        moved = 1'b0;
        while (model_pos != t) begin
            up        = goes_up(model_pos, t);
            model_pos = advance(model_pos, up);
            sb.push_back('{done: 1'b0, pos: model_pos, flag: up});
            moved = 1'b1;
        end
        if (moved) sb.push_back('{done: 1'b1, pos: model_pos, flag: 1'b1});
    endtask

    task automatic applyStimulus(input logic [31:0] tgt);
        @(negedge clk);
        planMove(tgt);
        target_pos = tgt;
        en         = 1'b1;
    endtask

    task automatic waitIdle(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: move still busy with %0d events pending, required idle", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic waitStepHigh(input string name, input bit match_pos, input logic [31:0] pos);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (step && (!match_pos || current_pos == pos)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: step high not seen (pos 0x%08h), required step=1", name, current_pos);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        model_pos = 32'd0;
    endtask

    // Monitor: pulse shape, direction discipline and scoreboard pops.
    logic prev_step = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_dir  = 1'b0;
    int   hi_cnt    = 0;
    int   gap       = 0;
    int   dir_age   = 0;
    bit   clean     = 1'b0;

    always @(negedge clk) begin
        ev_t e;
        if (reset) begin
            hi_cnt  = 0;
            clean   = 1'b0;
            dir_age = 0;
        end else begin
            gap++;
            if (dir !== prev_dir) begin
                checkOutput("dir_change_while_step", {31'd0, step | prev_step}, 32'd0);
                dir_age = 0;
                clean   = 1'b0;
            end else begin
                dir_age++;
            end
            if (!busy) clean = 1'b0;
            if (step && !prev_step) begin
                checkOutput("dir_setup_before_rise", {31'd0, dir_age >= DIR_SETUP}, 32'd1);
                if (clean) checkOutput("step_period", gap, STEP_PERIOD);
                gap    = 0;
                clean  = 1'b1;
                hi_cnt = 1;
            end else if (step) begin
                hi_cnt++;
            end
            if (!step && prev_step) begin
                checkOutput("pulse_width", hi_cnt, PULSE_WIDTH);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_step: pulse to pos 0x%08h, required no pulse", current_pos);
                end else begin
                    e = sb.pop_front();
                    checkOutput("event_is_step", {31'd0, e.done}, 32'd0);
                    checkOutput("step_pos", current_pos, e.pos);
                    checkOutput("step_dir", {31'd0, dir}, {31'd0, e.flag});
                end
            end
            if (!busy && prev_busy) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_done: busy fell at pos 0x%08h, required still moving", current_pos);
                end else begin
                    e = sb.pop_front();
                    checkOutput("event_is_done", {31'd0, e.done}, 32'd1);
                    checkOutput("done_pos", current_pos, e.pos);
                    checkOutput("done_at_target", {31'd0, at_target}, {31'd0, e.flag});
                end
            end
        end
        prev_step = step;
        prev_busy = busy;
        prev_dir  = dir;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] tgt;
        reset      = 1'b1;
        en         = 1'b0;
        target_pos = 32'd0;
        model_pos  = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_step", {31'd0, step}, 32'd0);
        checkOutput("reset_dir", {31'd0, dir}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_pos", current_pos, 32'd0);
        checkOutput("reset_at_target", {31'd0, at_target}, 32'd1);
        reset = 1'b0;

        // Basic forward move of three steps.
        applyStimulus(32'd3);
        waitIdle("move_to_3");
        checkOutput("pos_after_3", current_pos, model_pos);
        checkOutput("at_target_after_3", {31'd0, at_target}, 32'd1);

        applyStimulus(32'd2);
        waitIdle("move_to_2");

        // Retarget while a pulse is high: that pulse finishes, then reverse.
        @(negedge clk);
        target_pos = 32'd5;
        en         = 1'b1;
        pushStep();
        waitStepHigh("retarget_rise", 1'b0, 32'd0);
        target_pos = 32'd1;
        planMove(32'd1);
        waitIdle("retarget_move");
        checkOutput("pos_after_retarget", current_pos, model_pos);

        // Reset in the middle of a pulse.
        applyStimulus(32'd10);
        waitStepHigh("reset_mid_pulse_wait", 1'b1, 32'd4);
        reset = 1'b1;
        en    = 1'b0;
        sb.delete();
        @(negedge clk);
        checkOutput("midreset_step", {31'd0, step}, 32'd0);
        checkOutput("midreset_pos", current_pos, 32'd0);
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset_dir", {31'd0, dir}, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        model_pos = 32'd0;

        // Negative target across zero.
        applyStimulus(32'hFFFF_FFFE);
        waitIdle("move_to_minus2");
        checkOutput("pos_minus2", current_pos, eff_of(32'hFFFF_FFFE));
        checkOutput("at_target_minus2", {31'd0, at_target}, 32'd1);

        // Disabled: no motion; then enable just long enough for one pulse.
        doReset();
        target_pos = 32'd7;
        repeat (20) @(negedge clk);
        checkOutput("disabled_busy", {31'd0, busy}, 32'd0);
        checkOutput("disabled_at_target", {31'd0, at_target}, 32'd0);
        checkOutput("disabled_pos", current_pos, 32'd0);
        pushStep();
        sb.push_back('{done: 1'b1, pos: model_pos, flag: (eff_of(32'd7) == model_pos)});
        en = 1'b1;
        waitStepHigh("single_pulse_rise", 1'b0, 32'd0);
        en = 1'b0;
        waitIdle("single_pulse");
        checkOutput("single_pulse_pos", current_pos, 32'd1);

`ifdef MOTOR_WRAP_EN
        doReset();
        applyStimulus(32'd198);
        waitIdle("wrap_to_198");
        checkOutput("wrap_pos_198", current_pos, 32'd198);
        applyStimulus(32'd400);
        waitIdle("wrap_to_400");
        checkOutput("wrap_pos_400", current_pos, 32'd0);
`endif

        // Randomized moves against the path model.
        for (int i = 0; i < 12; i++) begin
`ifdef MOTOR_WRAP_EN
            tgt = 32'($urandom_range(0, 2 * SPR - 1));
`else
            tgt = model_pos + 32'($urandom_range(0, 12)) - 32'd6;
`endif
            applyStimulus(tgt);
            waitIdle("random_move");
            checkOutput("random_pos", current_pos, model_pos);
            checkOutput("random_at_target", {31'd0, at_target}, 32'd1);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stepper_position_ctrl.md
STEPPER_POSITION_CTRL -- requirements
Module: stepper_position_ctrl

Interface
REQ-001 Parameter STEP_PERIOD, default 50000: clocks per step, from pulse rise to next rise; SHALL be > PULSE_WIDTH.
REQ-002 Parameter PULSE_WIDTH, default 5000: clocks step is held high; SHALL be >= 1.
REQ-003 Parameter DIR_SETUP, default 100: clocks dir is stable before the first rise after any direction change; SHALL be >= 1.
REQ-004 Parameter STEPS_PER_REV, default 200: steps per wheel revolution; used only in wrap mode.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 en  input  1  motion enable.
REQ-008 target_pos  input  32  commanded position, two's complement; driven by the RAM motor-position word (address 10).
REQ-009 step  output  1  step pulse to the driver.
REQ-010 dir  output  1  direction; 1 = increment position, 0 = decrement.
REQ-011 current_pos  output  32  registered position count.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 at_target  output  1  high when in IDLE and current_pos equals the effective target.

Function
REQ-014 FSM states: IDLE, SETUP, PULSE_HI, PULSE_LO; one shared down-counter times every state.
REQ-015 IDLE: if en=1 and target differs from current_pos, latch the target, compute dir, and go to SETUP; otherwise stay; step=0.
REQ-016 SETUP: step=0, dir driven with the new value, for DIR_SETUP cycles, then go to PULSE_HI.
REQ-017 PULSE_HI: step=1 for exactly PULSE_WIDTH cycles; current_pos changes by +/-1 per dir on the cycle step falls.
REQ-018 PULSE_LO: step=0 for STEP_PERIOD-PULSE_WIDTH cycles, then re-sample en and target_pos.
REQ-019 At the end of PULSE_LO: same direction still needed -> PULSE_HI; opposite direction -> SETUP with dir flipped; target reached or en=0 -> IDLE.
REQ-020 A target change is acted on only at a step boundary; a pulse in progress is never shortened or extended.
REQ-021 Deasserting en mid-move completes the current pulse and its PULSE_LO period, then enters IDLE.
REQ-022 Non-wrap mode: dir=1 iff target > current_pos, compared as signed values; position arithmetic wraps modulo 2^32 without a flag.
REQ-023 dir changes only on entry to SETUP; it is never changed while step=1.

Reset
REQ-024 reset=1 SHALL, on the next edge, force state=IDLE, step=0, dir=0, current_pos=0, busy=0, latched target=0, counter=0, overriding en and any in-progress pulse.
REQ-025 at_target SHALL read 1 on the first cycle after reset only if the effective target is 0.

Configuration
REQ-026 Macro MOTOR_WRAP_EN defined: the effective target is target_pos taken as unsigned modulo STEPS_PER_REV.
REQ-027 With MOTOR_WRAP_EN defined, current_pos stays within 0..STEPS_PER_REV-1: STEPS_PER_REV-1 +1 -> 0, and 0 -1 -> STEPS_PER_REV-1.
REQ-028 With MOTOR_WRAP_EN defined, dir=1 iff forward distance (target-current) mod STEPS_PER_REV <= STEPS_PER_REV/2; a tie goes forward.
REQ-029 Macro MOTOR_WRAP_EN undefined: linear signed behaviour per REQ-022; no modulo logic is synthesized.

Verification (STEP_PERIOD=10, PULSE_WIDTH=3, DIR_SETUP=2)
REQ-030 reset, then en=1, target_pos=3 -> 2 SETUP cycles, dir=1, 3 pulses each 3 cycles high at 10-cycle spacing; current_pos 1,2,3; busy falls; at_target=1.
REQ-031 from 0, target_pos=0xFFFFFFFE (non-wrap) -> dir=0, 2 pulses, current_pos=0xFFFFFFFE, at_target=1.
REQ-032 target 5 at pos 2, changed to 1 while step=1 -> pulse completes, pos=3; PULSE_LO completes; SETUP 2 cycles with dir=0; pulses down to pos=1.
REQ-033 reset asserted during PULSE_HI at pos 4 -> next cycle step=0, current_pos=0, busy=0, state IDLE.
REQ-034 en=0, target_pos=7 -> no pulses, busy=0, at_target=0; then en=1 and dropped after the first rise -> exactly 1 pulse, pos=1, IDLE.
REQ-035 MOTOR_WRAP_EN defined, STEPS_PER_REV=200, pos 0, target 198 -> dir=0, 2 pulses, current_pos 199 then 198; target 400 -> effective 0.
